// File: rtl/disp_chan_sched.sv
// Channel scheduler for the 8-channel display multiplexer: manual, timed scan and
// round-robin attention ownership of the channel select and its load pulse.
module disp_chan_sched #(
    parameter int unsigned DWELL = 50_000_000,
    parameter int unsigned HOLD  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_auto,
    input  logic [2:0] man_sel,
    input  logic [7:0] attn_req,
    output logic [2:0] Test,
    output logic       EN,
    output logic [7:0] attn_pend,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StMan  = 2'd0,
        StScan = 2'd1,
        StAttn = 2'd2
    } state_e;

    localparam logic [31:0] DwellLast = 32'(DWELL - 1);
    localparam logic [31:0] HoldLast  = 32'(HOLD - 1);

    state_e      st;
    logic [2:0]  scan_idx;
    logic [2:0]  rr_ptr;
    logic [31:0] dwell_cnt;
    logic [31:0] hold_cnt;
    logic        init;

    logic [2:0]  grant_ch;
    logic [2:0]  cand;
    logic        found;
    logic        pend_any;
    logic        hold_done;
    logic        dwell_done;
    logic        do_grant;
    logic [7:0]  grant_mask;

    assign state = st;

    // Round-robin search: first pending bit strictly after rr_ptr, wrapping mod 8.
    always_comb begin
        grant_ch = rr_ptr;
        cand     = '0;
        found    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = rr_ptr + 3'(i);
            if (!found && attn_pend[cand]) begin
                grant_ch = cand;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        pend_any   = |attn_pend;
        hold_done  = (hold_cnt == HoldLast);
        dwell_done = (dwell_cnt == DwellLast);
        do_grant   = !init && pend_any && ((st != StAttn) || hold_done);
        grant_mask = do_grant ? (8'b1 << grant_ch) : 8'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Test      <= '0;
            EN        <= 1'b0;
            attn_pend <= '0;
            st        <= StMan;
            scan_idx  <= '0;
            dwell_cnt <= '0;
            hold_cnt  <= '0;
            rr_ptr    <= 3'd7;
            init      <= 1'b1;
        end else begin
            // A fresh request on the bit being granted keeps it pending.
            attn_pend <= (attn_pend & ~grant_mask) | attn_req;
            EN        <= 1'b0;
            if (init) begin
                init <= 1'b0;
                EN   <= 1'b1;
            end else if (do_grant) begin
                st       <= StAttn;
                Test     <= grant_ch;
                rr_ptr   <= grant_ch;
                hold_cnt <= '0;
                EN       <= 1'b1;
            end else begin
                case (st)
                    StMan: begin
                        if (mode_auto) begin
                            st        <= StScan;
                            dwell_cnt <= '0;
                            Test      <= scan_idx;
                            EN        <= 1'b1;
                        end else begin
                            Test <= man_sel;
                            EN   <= (man_sel != Test);
                        end
                    end
                    StScan: begin
                        if (!mode_auto) begin
                            st   <= StMan;
                            Test <= man_sel;
                            EN   <= (man_sel != Test);
                        end else if (dwell_done) begin
                            dwell_cnt <= '0;
                            scan_idx  <= scan_idx + 3'd1;
                            Test      <= scan_idx + 3'd1;
                            EN        <= 1'b1;
                        end else begin
                            dwell_cnt <= dwell_cnt + 32'd1;
                        end
                    end
                    StAttn: begin
                        // Reaching here on expiry means nothing is pending.
                        if (hold_done) begin
                            EN <= 1'b1;
                            if (mode_auto) begin
                                st        <= StScan;
                                dwell_cnt <= '0;
                                Test      <= scan_idx;
                            end else begin
                                st   <= StMan;
                                Test <= man_sel;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                    default: st <= StMan;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_chan_sched.sv
// Self-checking bench for disp_chan_sched: fixed vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_disp_chan_sched;

    localparam int DW = 3;
    localparam int HD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_auto;
    logic [2:0] man_sel;
    logic [7:0] attn_req;
    logic [2:0] Test;
    logic       EN;
    logic [7:0] attn_pend;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    disp_chan_sched #(.DWELL(DW), .HOLD(HD)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_auto (mode_auto),
        .man_sel   (man_sel),
        .attn_req  (attn_req),
        .Test      (Test),
        .EN        (EN),
        .attn_pend (attn_pend),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Reference model: owner of the display plus remaining-time counters.
    int       m_test, m_en, m_state, m_scan, m_ptr, m_scan_left, m_hold_left;
    bit [7:0] m_pend;
    bit       m_init;

    function automatic int next_grant(bit [7:0] p, int ptr);
        for (int k = 1; k <= 8; k++) begin
            if (p[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit ma, input int ms, input bit [7:0] req);
        int g;
        g = -1;
        if (r) begin
            m_test = 0; m_en = 0; m_pend = '0; m_state = 0; m_scan = 0;
            m_ptr = 7; m_init = 1'b1; m_scan_left = DW; m_hold_left = HD;
            return;
        end
        m_en = 0;
        if (m_init) begin
            m_init = 1'b0;
            m_en   = 1;
        end else if (m_pend != 0 && (m_state != 2 || m_hold_left == 1)) begin
            g = next_grant(m_pend, m_ptr);
            m_state = 2; m_test = g; m_ptr = g; m_hold_left = HD; m_en = 1;
        end else if (m_state == 0) begin
            if (ma) begin
                m_state = 1; m_scan_left = DW; m_test = m_scan; m_en = 1;
            end else begin
                m_en = (ms != m_test) ? 1 : 0;
                m_test = ms;
            end
        end else if (m_state == 1) begin
            if (!ma) begin
                m_en = (ms != m_test) ? 1 : 0;
                m_test = ms; m_state = 0;
            end else if (m_scan_left == 1) begin
                m_scan = (m_scan + 1) % 8; m_test = m_scan; m_scan_left = DW; m_en = 1;
            end else begin
                m_scan_left--;
            end
        end else begin
            if (m_hold_left == 1) begin
                m_en = 1;
                if (ma) begin
                    m_state = 1; m_scan_left = DW; m_test = m_scan;
                end else begin
                    m_state = 0; m_test = ms;
                end
            end else begin
                m_hold_left--;
            end
        end
        if (g >= 0) m_pend[g] = 1'b0;
        m_pend = m_pend | req;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit ma, input int ms, input bit [7:0] req,
                        input bit mchk);
        rst = r; mode_auto = ma; man_sel = 3'(ms); attn_req = req;
        @(posedge clk);
        model_step(r, ma, ms, req);
        #1;
        if (mchk) begin
            chk("model_test", int'(Test), m_test);
            chk("model_en", int'(EN), m_en);
            chk("model_pend", int'(attn_pend), int'(m_pend));
            chk("model_state", int'(state), m_state);
        end
    endtask

    task automatic expect_out(input string nm, input int t, input int e, input int s);
        chk({nm, "_test"}, int'(Test), t);
        chk({nm, "_en"}, int'(EN), e);
        chk({nm, "_state"}, int'(state), s);
    endtask

    typedef struct {
        bit       r;
        bit       ma;
        int       ms;
        bit [7:0] req;
        int       t;
        int       en;
        int       p;
        int       s;
    } vec_t;

    function automatic vec_t mk(bit r, bit ma, int ms, int req, int t, int en, int p, int s);
        vec_t v;
        v.r = r; v.ma = ma; v.ms = ms; v.req = 8'(req);
        v.t = t; v.en = en; v.p = p; v.s = s;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        bit ma;
        int ms;
        bit r;
        bit [7:0] req;

        tbl[0]  = mk(1, 0, 5, 'h00, 0, 0, 'h00, 0);
        tbl[1]  = mk(0, 0, 5, 'h00, 0, 1, 'h00, 0);
        tbl[2]  = mk(0, 0, 5, 'h00, 5, 1, 'h00, 0);
        tbl[3]  = mk(0, 0, 5, 'h00, 5, 0, 'h00, 0);
        tbl[4]  = mk(0, 0, 5, 'h00, 5, 0, 'h00, 0);
        tbl[5]  = mk(0, 0, 2, 'h00, 2, 1, 'h00, 0);
        tbl[6]  = mk(0, 0, 2, 'h00, 2, 0, 'h00, 0);
        tbl[7]  = mk(0, 0, 2, 'h01, 2, 0, 'h01, 0);
        tbl[8]  = mk(0, 0, 2, 'h00, 0, 1, 'h00, 2);
        tbl[9]  = mk(0, 0, 2, 'h00, 0, 0, 'h00, 2);
        tbl[10] = mk(0, 0, 2, 'h00, 0, 0, 'h00, 2);
        tbl[11] = mk(0, 0, 2, 'h00, 0, 0, 'h00, 2);
        tbl[12] = mk(0, 0, 2, 'h00, 2, 1, 'h00, 0);
        tbl[13] = mk(0, 1, 2, 'h00, 0, 1, 'h00, 1);
        tbl[14] = mk(0, 1, 2, 'h00, 0, 0, 'h00, 1);
        tbl[15] = mk(0, 1, 2, 'h00, 0, 0, 'h00, 1);
        tbl[16] = mk(0, 1, 2, 'h00, 1, 1, 'h00, 1);

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].r, tbl[i].ma, tbl[i].ms, tbl[i].req, 1'b0);
            chk($sformatf("tbl%0d_test", i), int'(Test), tbl[i].t);
            chk($sformatf("tbl%0d_en", i), int'(EN), tbl[i].en);
            chk($sformatf("tbl%0d_pend", i), int'(attn_pend), tbl[i].p);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].s);
        end

        // Scan wrap: each channel held DW cycles, one EN per change.
        tick(1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1); expect_out("wrap_init", 0, 1, 0);
        tick(0, 1, 0, 0, 1); expect_out("wrap_entry", 0, 1, 1);
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            for (int k = 0; k < DW; k++) begin
                tick(0, 1, 0, 0, 1);
                expect_out($sformatf("wrap_c%0d_k%0d", c, k), c % 8, (k == 0) ? 1 : 0, 1);
            end
        end

        // Attention round-robin then scan resumes at the interrupted channel.
        tick(1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 'h84, 1); chk("rr_pend", int'(attn_pend), 'h84);
        tick(0, 1, 0, 0, 1); expect_out("rr_g2", 2, 1, 2);
        for (int k = 0; k < HD - 1; k++) begin
            tick(0, 1, 0, 0, 1); expect_out("rr_h2", 2, 0, 2);
        end
        tick(0, 1, 0, 0, 1); expect_out("rr_g7", 7, 1, 2);
        for (int k = 0; k < HD - 1; k++) begin
            tick(0, 1, 0, 0, 1); expect_out("rr_h7", 7, 0, 2);
        end
        tick(0, 1, 0, 0, 1); expect_out("rr_resume", 0, 1, 1);
        tick(0, 1, 0, 0, 1); expect_out("rr_dw1", 0, 0, 1);
        tick(0, 1, 0, 0, 1); expect_out("rr_dw2", 0, 0, 1);
        tick(0, 1, 0, 0, 1); expect_out("rr_next", 1, 1, 1);

        // Request held across its own grant edge stays pending and is re-granted.
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 'h08, 1);
        tick(0, 0, 0, 'h08, 1); expect_out("sw_g3", 3, 1, 2);
        chk("sw_pend", int'(attn_pend), 'h08);
        for (int k = 0; k < HD - 1; k++) tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1); expect_out("sw_regrant", 3, 1, 2);
        chk("sw_pend_clr", int'(attn_pend), 0);
        for (int k = 0; k < HD - 1; k++) tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1); expect_out("sw_back", 0, 1, 0);

        // mode_auto dropped mid-hold only takes effect at expiry.
        tick(1, 1, 6, 0, 1);
        tick(0, 1, 6, 0, 1);
        tick(0, 1, 6, 0, 1);
        tick(0, 1, 6, 'h20, 1);
        tick(0, 1, 6, 0, 1); expect_out("mc_g5", 5, 1, 2);
        for (int k = 0; k < HD - 1; k++) begin
            tick(0, 0, 6, 0, 1); expect_out("mc_hold", 5, 0, 2);
        end
        tick(0, 0, 6, 0, 1); expect_out("mc_man", 6, 1, 0);

        // Mid-operation reset clears pending bits and the round-robin pointer.
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 'h11, 1);
        tick(0, 0, 0, 'h40, 1); expect_out("mr_g0", 0, 1, 2);
        tick(1, 0, 0, 0, 1); expect_out("mr_rst", 0, 0, 0);
        chk("mr_pend", int'(attn_pend), 0);
        tick(0, 0, 0, 'h81, 1); expect_out("mr_init", 0, 1, 0);
        tick(0, 0, 0, 0, 1); expect_out("mr_grant", 0, 1, 2);
        chk("mr_pend_left", int'(attn_pend), 'h80);

        // Randomized traffic against the reference model.
        ma = 1'b1;
        ms = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ma = ~ma;
            if ($urandom_range(0, 7) == 0) ms = int'($urandom_range(0, 7));
            r = ($urandom_range(0, 399) == 0);
            req = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            tick(r, ma, ms, req, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
